// File: rtl/multi_clock_gate.sv
// Per-channel clock gate with enable hold-off; each channel runs an OFF/ON/HOLD FSM.
// Optional macro MULTI_CLOCK_GATE_TEST_OVERRIDE_EN adds test_en to force every gate open.
module multi_clock_gate #(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef MULTI_CLOCK_GATE_TEST_OVERRIDE_EN
  input  logic              test_en,
`endif
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] gated_clk,
  output logic [NUM_CH-1:0] ch_active,
  output logic              all_idle
);

  // state   | meaning
  // ST_OFF  | gate closed, waiting for ch_en
  // ST_ON   | gate open, ch_en asserted
  // ST_HOLD | ch_en dropped, gate kept open until hold counter expires
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t             state_q [NUM_CH];
  state_t             state_d [NUM_CH];
  logic [CNT_W-1:0]   cnt_q   [NUM_CH];
  logic [CNT_W-1:0]   cnt_d   [NUM_CH];
  logic [NUM_CH-1:0]  ch_active_q;
  logic [NUM_CH-1:0]  ch_active_d;
  logic               all_idle_q;
  logic               all_idle_d;
  logic [NUM_CH-1:0]  gate_req;
  logic [NUM_CH-1:0]  gate_q;

  // The counter is loaded with HOLD_CYCLES so the gate stays open for
  // HOLD_CYCLES+1 more rising edges after the request is seen low.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_OFF: begin
          if (ch_en[i]) state_d[i] = ST_ON;
        end
        ST_ON: begin
          if (!ch_en[i]) begin
            if (HOLD_CYCLES > 0) begin
              state_d[i] = ST_HOLD;
              cnt_d[i]   = CNT_W'(HOLD_CYCLES);
            end else begin
              state_d[i] = ST_OFF;
            end
          end
        end
        ST_HOLD: begin
          if (ch_en[i]) begin
            state_d[i] = ST_ON;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = ST_OFF;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_OFF;
          cnt_d[i]   = '0;
        end
      endcase
      ch_active_d[i] = (state_d[i] != ST_OFF);
`ifdef MULTI_CLOCK_GATE_TEST_OVERRIDE_EN
      gate_req[i]    = (state_q[i] != ST_OFF) | test_en;
`else
      gate_req[i]    = (state_q[i] != ST_OFF);
`endif
    end
    all_idle_d = ~|ch_active_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= '0;
      end
      ch_active_q <= '0;
      all_idle_q  <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      ch_active_q <= ch_active_d;
      all_idle_q  <= all_idle_d;
    end
  end

  // Capturing while clk is low means the gate only changes during the low
  // phase, so the AND below never truncates a high phase.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q <= '0;
    end else begin
      gate_q <= gate_req;
    end
  end

  assign gated_clk = {NUM_CH{clk}} & gate_q;
  assign ch_active = ch_active_q;
  assign all_idle  = all_idle_q;

endmodule

// File: tb/tb_multi_clock_gate.sv
// Directed scoreboard bench for multi_clock_gate: one HOLD_CYCLES=8 instance and one HOLD_CYCLES=0 instance.
module tb_multi_clock_gate;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ch_en;
  logic [3:0] ch_en0;
  logic [3:0] gated_clk, ch_active;
  logic       all_idle;
  logic [3:0] gated_clk0, ch_active0;
  logic       all_idle0;
`ifdef MULTI_CLOCK_GATE_TEST_OVERRIDE_EN
  logic       test_en;
`endif

  always #5 clk = ~clk;

  multi_clock_gate #(.NUM_CH(4), .HOLD_CYCLES(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MULTI_CLOCK_GATE_TEST_OVERRIDE_EN
    .test_en   (test_en),
`endif
    .ch_en     (ch_en),
    .gated_clk (gated_clk),
    .ch_active (ch_active),
    .all_idle  (all_idle)
  );

  multi_clock_gate #(.NUM_CH(4), .HOLD_CYCLES(0), .CNT_W(8)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MULTI_CLOCK_GATE_TEST_OVERRIDE_EN
    .test_en   (1'b0),
`endif
    .ch_en     (ch_en0),
    .gated_clk (gated_clk0),
    .ch_active (ch_active0),
    .all_idle  (all_idle0)
  );

  // rising-edge counters on each gated clock
  int pc0 = 0, pc1 = 0, pc2 = 0, pc3 = 0, pz2 = 0;
  always @(posedge gated_clk[0])  pc0++;
  always @(posedge gated_clk[1])  pc1++;
  always @(posedge gated_clk[2])  pc2++;
  always @(posedge gated_clk[3])  pc3++;
  always @(posedge gated_clk0[2]) pz2++;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic compare(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int s0, s1, s2, s3;

  initial begin
    rst_n  = 1'b0;
    ch_en  = 4'b0000;
    ch_en0 = 4'b0000;
`ifdef MULTI_CLOCK_GATE_TEST_OVERRIDE_EN
    test_en = 1'b0;
`endif
    #12;
    expect_val("rst_active", 32'h0);  compare(32'(ch_active));
    expect_val("rst_idle",   32'h1);  compare(32'(all_idle));
    expect_val("rst_gated",  32'h0);  compare(32'(gated_clk));
    cyc();
    rst_n = 1'b1;

    // idle for 20 cycles
    s0 = pc0; s1 = pc1; s2 = pc2; s3 = pc3;
    for (int n = 0; n < 20; n++) cyc();
    expect_val("idle_pulses", 32'h0);  compare(32'((pc0 - s0) + (pc1 - s1) + (pc2 - s2) + (pc3 - s3)));
    expect_val("idle_active", 32'h0);  compare(32'(ch_active));
    expect_val("idle_all",    32'h1);  compare(32'(all_idle));

    // ch0 requested for 5 posedges, then released: 5 + 9 pulses
    s0 = pc0; s1 = pc1; s2 = pc2; s3 = pc3;
    ch_en = 4'b0001;
    expect_val("ch0_no_partial", 32'h0);
    expect_val("ch0_active_p0",  32'h1);
    expect_val("ch0_idle_p0",    32'h0);
    cyc();
    compare(32'(gated_clk[0]));
    compare(32'(ch_active));
    compare(32'(all_idle));
    for (int n = 1; n <= 4; n++) begin
      if (n == 1) expect_val("ch0_first_pulse", 32'h1);
      cyc();
      if (n == 1) compare(32'(gated_clk[0]));
    end
    ch_en = 4'b0000;
    for (int n = 5; n <= 20; n++) begin
      if (n == 13) expect_val("ch0_hold_active", 32'h1);
      if (n == 14) begin
        expect_val("ch0_last_pulse", 32'h1);
        expect_val("ch0_off_active", 32'h0);
        expect_val("ch0_off_idle",   32'h1);
      end
      if (n == 15) expect_val("ch0_after_last", 32'h0);
      cyc();
      if (n == 13) compare(32'(ch_active[0]));
      if (n == 14) begin
        compare(32'(gated_clk[0]));
        compare(32'(ch_active[0]));
        compare(32'(all_idle));
      end
      if (n == 15) compare(32'(gated_clk[0]));
    end
    expect_val("ch0_pulse_count", 32'd14);  compare(32'(pc0 - s0));
    expect_val("ch0_others_flat", 32'd0);   compare(32'((pc1 - s1) + (pc2 - s2) + (pc3 - s3)));

    // ch1 dropped 4 cycles inside the hold window, then re-raised
    s1 = pc1;
    ch_en = 4'b0010;
    for (int n = 0; n < 4; n++) cyc();
    ch_en = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      expect_val("ch1_gap_active", 32'h1);
      expect_val("ch1_gap_gated",  32'h1);
      cyc();
      compare(32'(ch_active[1]));
      compare(32'(gated_clk[1]));
    end
    ch_en = 4'b0010;
    for (int n = 0; n < 3; n++) cyc();
    ch_en = 4'b0000;
    for (int n = 0; n < 15; n++) cyc();
    expect_val("ch1_pulse_count", 32'd20);  compare(32'(pc1 - s1));
    expect_val("ch1_idle",        32'h1);   compare(32'(all_idle));

    // ch1 and ch3 start together, released at different times
    s1 = pc1; s3 = pc3;
    ch_en = 4'b1010;
    expect_val("multi_active", 32'hA);
    cyc();
    compare(32'(ch_active));
    cyc();
    ch_en = 4'b1000;
    for (int n = 0; n < 4; n++) cyc();
    ch_en = 4'b0000;
    for (int n = 0; n < 14; n++) cyc();
    expect_val("multi_ch1_count", 32'd11);  compare(32'(pc1 - s1));
    expect_val("multi_ch3_count", 32'd15);  compare(32'(pc3 - s3));

    // zero-hold instance: single-cycle request gives one pulse
    s2 = pc2; s0 = pz2;
    ch_en0 = 4'b0100;
    expect_val("h0_no_partial", 32'h0);
    expect_val("h0_active_p0",  32'h4);
    expect_val("h0_idle_p0",    32'h0);
    cyc();
    compare(32'(gated_clk0[2]));
    compare(32'(ch_active0));
    compare(32'(all_idle0));
    ch_en0 = 4'b0000;
    expect_val("h0_pulse",     32'h1);
    expect_val("h0_active_p1", 32'h0);
    expect_val("h0_idle_p1",   32'h1);
    cyc();
    compare(32'(gated_clk0[2]));
    compare(32'(ch_active0));
    compare(32'(all_idle0));
    for (int n = 0; n < 5; n++) cyc();
    expect_val("h0_pulse_count", 32'd1);  compare(32'(pz2 - s0));
    expect_val("h0_main_flat",   32'd0);  compare(32'(pc2 - s2));

    // async reset during a high phase with every channel on
    ch_en = 4'b1111;
    for (int n = 0; n < 3; n++) cyc();
    expect_val("pre_rst_gated", 32'hF);
    compare(32'(gated_clk));
    #1;
    rst_n = 1'b0;
    #1;
    expect_val("rst_mid_clk_high", 32'h1);
    expect_val("rst_mid_gated",    32'h0);
    expect_val("rst_mid_active",   32'h0);
    expect_val("rst_mid_idle",     32'h1);
    compare(32'(clk));
    compare(32'(gated_clk));
    compare(32'(ch_active));
    compare(32'(all_idle));
    ch_en = 4'b0000;
    cyc();
    #3;
    rst_n = 1'b1;
    s0 = pc0; s1 = pc1; s2 = pc2; s3 = pc3;
    for (int n = 0; n < 5; n++) cyc();
    expect_val("post_rst_flat", 32'd0);
    compare(32'((pc0 - s0) + (pc1 - s1) + (pc2 - s2) + (pc3 - s3)));
    ch_en = 4'b0100;
    expect_val("post_rst_no_partial", 32'h0);
    cyc();
    compare(32'(gated_clk[2]));
    expect_val("post_rst_first", 32'h1);
    cyc();
    compare(32'(gated_clk[2]));
    ch_en = 4'b0000;
    for (int n = 0; n < 12; n++) cyc();

`ifdef MULTI_CLOCK_GATE_TEST_OVERRIDE_EN
    // test override opens every gate without touching FSM status
    s0 = pc0; s1 = pc1; s2 = pc2; s3 = pc3;
    test_en = 1'b1;
    for (int n = 0; n < 10; n++) cyc();
    expect_val("tst_ch0", 32'd10);   compare(32'(pc0 - s0));
    expect_val("tst_ch3", 32'd10);   compare(32'(pc3 - s3));
    expect_val("tst_active", 32'h0); compare(32'(ch_active));
    expect_val("tst_idle",   32'h1); compare(32'(all_idle));
    test_en = 1'b0;
    cyc();
    cyc();
`endif

    expect_val("sb_drained", 32'd0);
    compare(32'(sb.size() - 1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
